// File: rtl/mem_wb_stage.sv
// MEM stage of the 5-stage MIPS pipeline: decodes the load/store in IR_M, accesses the
// word-addressed data memory with sub-word merge/extension, and registers the MEM/WB fields.
module mem_wb_stage #(
    parameter int unsigned DM_WORDS = 1024,
    parameter int unsigned DM_AW    = 10
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_ir_m,
    input  logic [31:0] i_pc8_m,
    input  logic [31:0] i_ao_m,
    input  logic [31:0] i_rdata2_m,
    input  logic [4:0]  i_regwrite_m,
    output logic [31:0] o_ir_w,
    output logic [31:0] o_pc8_w,
    output logic [31:0] o_ao_w,
    output logic [31:0] o_dr_w,
    output logic [4:0]  o_regwrite_w,
    output logic [1:0]  o_aderr_w
);

    typedef enum logic [1:0] {SzNone, SzByte, SzHalf, SzWord} size_e;

    logic [31:0]      r_mem [DM_WORDS];
    logic [31:0]      r_ir_w;
    logic [31:0]      r_pc8_w;
    logic [31:0]      r_ao_w;
    logic [31:0]      r_dr_w;
    logic [4:0]       r_regwrite_w;
    logic [1:0]       r_aderr_w;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_signed;
    size_e            w_size;
    logic             w_misalign;
    logic             w_oor;
    logic             w_fault;
    logic             w_store_en;
    logic [DM_AW-1:0] w_idx;
    logic [31:0]      w_rword;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_ldata;
    logic [31:0]      w_wdata;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_signed   = 1'b0;
        w_size     = SzNone;
        unique case (i_ir_m[31:26])
            6'b100011: begin w_is_load = 1'b1;  w_size = SzWord; end
            6'b100001: begin w_is_load = 1'b1;  w_size = SzHalf; w_signed = 1'b1; end
            6'b100101: begin w_is_load = 1'b1;  w_size = SzHalf; end
            6'b100000: begin w_is_load = 1'b1;  w_size = SzByte; w_signed = 1'b1; end
            6'b100100: begin w_is_load = 1'b1;  w_size = SzByte; end
            6'b101011: begin w_is_store = 1'b1; w_size = SzWord; end
            6'b101001: begin w_is_store = 1'b1; w_size = SzHalf; end
            6'b101000: begin w_is_store = 1'b1; w_size = SzByte; end
            default:   ;
        endcase
    end

    assign w_misalign = ((w_size == SzWord) && (i_ao_m[1:0] != 2'b00)) ||
                        ((w_size == SzHalf) && i_ao_m[0]);
    assign w_oor      = |i_ao_m[31:DM_AW+2];
    assign w_fault    = (w_is_load | w_is_store) & (w_misalign | w_oor);
    assign w_store_en = w_is_store & ~w_fault;
    assign w_idx      = i_ao_m[DM_AW+1:2];
    assign w_rword    = r_mem[w_idx];
    assign w_byte     = w_rword[{i_ao_m[1:0], 3'b000} +: 8];
    assign w_half     = i_ao_m[1] ? w_rword[31:16] : w_rword[15:0];

    // Load extension; faulting loads and non-loads deliver zero.
    always_comb begin
        w_ldata = 32'h0;
        if (w_is_load && !w_fault) begin
            unique case (w_size)
                SzByte:  w_ldata = {{24{w_signed & w_byte[7]}}, w_byte};
                SzHalf:  w_ldata = {{16{w_signed & w_half[15]}}, w_half};
                SzWord:  w_ldata = w_rword;
                default: w_ldata = 32'h0;
            endcase
        end
    end

    // Sub-word store merge: untouched lanes keep the current word contents.
    always_comb begin
        w_wdata = w_rword;
        unique case (w_size)
            SzByte:  w_wdata[{i_ao_m[1:0], 3'b000} +: 8] = i_rdata2_m[7:0];
            SzHalf:  w_wdata[{i_ao_m[1], 4'b0000} +: 16] = i_rdata2_m[15:0];
            SzWord:  w_wdata = i_rdata2_m;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_ir_w       <= 32'h0;
            r_pc8_w      <= 32'h0;
            r_ao_w       <= 32'h0;
            r_dr_w       <= 32'h0;
            r_regwrite_w <= 5'h0;
            r_aderr_w    <= 2'b00;
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                r_mem[i[DM_AW-1:0]] <= 32'h0;
            end
        end else begin
            if (w_store_en) begin
                r_mem[w_idx] <= w_wdata;
            end
            r_ir_w       <= i_ir_m;
            r_pc8_w      <= i_pc8_m;
            r_ao_w       <= i_ao_m;
            r_dr_w       <= w_ldata;
            r_regwrite_w <= (w_is_load && w_fault) ? 5'h0 : i_regwrite_m;
            r_aderr_w    <= {w_is_load & w_fault, w_is_store & w_fault};
        end
    end

    assign o_ir_w       = r_ir_w;
    assign o_pc8_w      = r_pc8_w;
    assign o_ao_w       = r_ao_w;
    assign o_dr_w       = r_dr_w;
    assign o_regwrite_w = r_regwrite_w;
    assign o_aderr_w    = r_aderr_w;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: byte-level memory model checked every cycle, plus literal
// expectations on directed load/store/fault/reset scenarios.
module tb_mem_wb_stage;

    localparam int unsigned DmWords = 1024;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir_m, pc8_m, ao_m, rd2_m;
    logic [4:0]  rw_m;
    logic [31:0] ir_w, pc8_w, ao_w, dr_w;
    logic [4:0]  rw_w;
    logic [1:0]  err_w;

    int n_tests;
    int n_fail;

    mem_wb_stage #(
        .DM_WORDS(DmWords),
        .DM_AW   (10)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_ir_m      (ir_m),
        .i_pc8_m     (pc8_m),
        .i_ao_m      (ao_m),
        .i_rdata2_m  (rd2_m),
        .i_regwrite_m(rw_m),
        .o_ir_w      (ir_w),
        .o_pc8_w     (pc8_w),
        .o_ao_w      (ao_w),
        .o_dr_w      (dr_w),
        .o_regwrite_w(rw_w),
        .o_aderr_w   (err_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory as words, accesses described by size in bytes.
    logic [31:0] mdl_mem [DmWords];
    logic [31:0] e_ir, e_pc8, e_ao, e_dr;
    logic [4:0]  e_rw;
    logic [1:0]  e_err;
    logic        mdl_ok = 1'b0;
    int          nbytes, shamt, wi;
    logic        is_ld, is_sgn, flt;
    logic [31:0] mask, v;

    always @(posedge clk) begin
        if (!rst_n) begin
            e_ir = 0; e_pc8 = 0; e_ao = 0; e_dr = 0; e_rw = 0; e_err = 0;
            for (int i = 0; i < DmWords; i++) mdl_mem[i] = 32'h0;
            mdl_ok = 1'b1;
        end else begin
            is_ld = 1'b0; is_sgn = 1'b0; nbytes = 0;
            case (ir_m[31:26])
                6'b100011: begin nbytes = 4; is_ld = 1; end
                6'b100001: begin nbytes = 2; is_ld = 1; is_sgn = 1; end
                6'b100101: begin nbytes = 2; is_ld = 1; end
                6'b100000: begin nbytes = 1; is_ld = 1; is_sgn = 1; end
                6'b100100: begin nbytes = 1; is_ld = 1; end
                6'b101011: nbytes = 4;
                6'b101001: nbytes = 2;
                6'b101000: nbytes = 1;
                default:   nbytes = 0;
            endcase
            flt   = (nbytes != 0) && (((ao_m % nbytes) != 0) || (ao_m >= DmWords * 4));
            wi    = int'(ao_m[11:2]);
            shamt = int'(ao_m % 4) * 8;
            mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            e_ir = ir_m; e_pc8 = pc8_m; e_ao = ao_m; e_rw = rw_m; e_dr = 0; e_err = 0;
            if (nbytes != 0 && is_ld) begin
                if (flt) begin
                    e_err = 2'b10;
                    e_rw  = 0;
                end else begin
                    v = (mdl_mem[wi] >> shamt) & mask;
                    if (is_sgn && v[8*nbytes-1]) v = v | ~mask;
                    e_dr = v;
                end
            end else if (nbytes != 0) begin
                if (flt) e_err = 2'b01;
                else mdl_mem[wi] = (mdl_mem[wi] & ~(mask << shamt)) | ((rd2_m & mask) << shamt);
            end
        end
        #1;
        if (mdl_ok) begin
            check("ir_w",  ir_w,  e_ir);
            check("pc8_w", pc8_w, e_pc8);
            check("ao_w",  ao_w,  e_ao);
            check("dr_w",  dr_w,  e_dr);
            check("rw_w",  {27'h0, rw_w},  {27'h0, e_rw});
            check("err_w", {30'h0, err_w}, {30'h0, e_err});
        end
    end

    // Present one M-stage instruction; returns once its W outputs are settled.
    task automatic cyc(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rd2,
                       input logic [4:0] rw, input logic rst);
        @(negedge clk);
        ir_m  = {op, 26'h0};
        ao_m  = ao;
        rd2_m = rd2;
        rw_m  = rw;
        pc8_m = 32'h3000 + ao;
        rst_n = rst;
        @(posedge clk);
        #2;
    endtask

    localparam logic [5:0] OpLw = 6'b100011, OpLh = 6'b100001, OpLhu = 6'b100101;
    localparam logic [5:0] OpLb = 6'b100000, OpLbu = 6'b100100, OpSw = 6'b101011;
    localparam logic [5:0] OpSh = 6'b101001, OpSb = 6'b101000;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; ir_m = 0; pc8_m = 0; ao_m = 0; rd2_m = 0; rw_m = 0;
        cyc(6'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        cyc(6'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        check("reset dr", dr_w, 32'h0);
        check("reset ir", ir_w, 32'h0);

        cyc(OpSw, 32'h10, 32'hDEAD_BEEF, 5'd0, 1'b1);
        check("sw err", {30'h0, err_w}, 32'h0);
        cyc(OpLw, 32'h10, 32'h0, 5'd8, 1'b1);
        check("lw after sw", dr_w, 32'hDEAD_BEEF);
        check("lw rw", {27'h0, rw_w}, 32'd8);

        cyc(OpSb, 32'h11, 32'h0000_0080, 5'd0, 1'b1);
        cyc(OpSh, 32'h12, 32'h0000_1234, 5'd0, 1'b1);
        cyc(OpLw, 32'h10, 32'h0, 5'd9, 1'b1);
        check("merged word", dr_w, 32'h1234_80EF);
        cyc(OpLb, 32'h11, 32'h0, 5'd9, 1'b1);
        check("lb sign", dr_w, 32'hFFFF_FF80);
        cyc(OpLbu, 32'h11, 32'h0, 5'd9, 1'b1);
        check("lbu zero", dr_w, 32'h0000_0080);
        cyc(OpLh, 32'h12, 32'h0, 5'd9, 1'b1);
        check("lh hi", dr_w, 32'h0000_1234);
        cyc(OpLh, 32'h10, 32'h0, 5'd9, 1'b1);
        check("lh lo sign", dr_w, 32'hFFFF_80EF);
        cyc(OpLhu, 32'h10, 32'h0, 5'd9, 1'b1);
        check("lhu lo", dr_w, 32'h0000_80EF);
        cyc(OpLb, 32'h13, 32'h0, 5'd9, 1'b1);
        check("lb lane3", dr_w, 32'h0000_0012);

        cyc(OpLw, 32'h13, 32'h0, 5'd9, 1'b1);
        check("lw misalign err", {30'h0, err_w}, 32'h2);
        check("lw misalign rw", {27'h0, rw_w}, 32'h0);
        check("lw misalign dr", dr_w, 32'h0);
        cyc(OpSh, 32'h11, 32'h0000_FFFF, 5'd0, 1'b1);
        check("sh misalign err", {30'h0, err_w}, 32'h1);
        cyc(OpLw, 32'h10, 32'h0, 5'd9, 1'b1);
        check("word 4 unchanged", dr_w, 32'h1234_80EF);

        cyc(OpLw, 32'h0000_1000, 32'h0, 5'd9, 1'b1);
        check("lw oor err", {30'h0, err_w}, 32'h2);
        cyc(OpSw, 32'h0000_1010, 32'h5555_AAAA, 5'd0, 1'b1);
        check("sw oor err", {30'h0, err_w}, 32'h1);
        cyc(OpLw, 32'h10, 32'h0, 5'd9, 1'b1);
        check("oor no alias", dr_w, 32'h1234_80EF);
        cyc(OpSw, 32'hFFC, 32'h0BAD_F00D, 5'd0, 1'b1);
        cyc(OpLw, 32'hFFC, 32'h0, 5'd3, 1'b1);
        check("top word", dr_w, 32'h0BAD_F00D);

        @(negedge clk);
        ir_m = 32'h0109_4021; ao_m = 32'h55; rw_m = 5'd8; pc8_m = 32'h3008; rd2_m = 32'h1;
        @(posedge clk); #2;
        check("addu ao", ao_w, 32'h55);
        check("addu pc8", pc8_w, 32'h3008);
        check("addu rw", {27'h0, rw_w}, 32'd8);
        check("addu dr", dr_w, 32'h0);
        cyc(6'b100010, 32'h10, 32'h0, 5'd4, 1'b1);
        check("non-mem op dr", dr_w, 32'h0);

        cyc(OpSw, 32'h20, 32'hCAFE_F00D, 5'd0, 1'b1);
        cyc(OpSw, 32'h24, 32'h1357_9BDF, 5'd0, 1'b0);
        check("reset ao", ao_w, 32'h0);
        check("reset pc8", pc8_w, 32'h0);
        cyc(OpLw, 32'h24, 32'h0, 5'd7, 1'b1);
        check("no write on reset", dr_w, 32'h0);
        check("first after reset", ao_w, 32'h24);
        cyc(OpLw, 32'h20, 32'h0, 5'd7, 1'b1);
        check("mem cleared", dr_w, 32'h0);
        cyc(OpLw, 32'h10, 32'h0, 5'd7, 1'b1);
        check("mem cleared w4", dr_w, 32'h0);
        cyc(6'h0, 32'h0, 32'h0, 5'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
